// File: rtl/uart_rx_configurable.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_configurable
// Brief    : Oversampling UART receiver with optional parity, one or two stop
//            bits and a single-word holding register with overrun detection.
//            Define UART_RX_MAJORITY_EN for 2-of-3 majority bit decisions.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_configurable #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_en,
    input  logic [15:0]          baud_div,
    input  logic [1:0]           parity_mode,
    input  logic                 stop2,
    input  logic                 rxd,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_ferror,
    output logic                 rx_perror,
    output logic                 rx_overrun
);

    localparam int                  c_TICK_W    = $clog2(OVERSAMPLE);
    localparam logic [c_TICK_W-1:0] c_last_tick = c_TICK_W'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [c_TICK_W-1:0] c_m0_tick   = c_TICK_W'(OVERSAMPLE / 2 - 2);
    localparam logic [c_TICK_W-1:0] c_m1_tick   = c_TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_TICK_W-1:0] c_vote_tick = c_TICK_W'(OVERSAMPLE / 2);
`else
    localparam logic [c_TICK_W-1:0] c_vote_tick = c_TICK_W'(OVERSAMPLE / 2 - 1);
`endif

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_start  = 3'd1;
    localparam logic [2:0] c_st_data   = 3'd2;
    localparam logic [2:0] c_st_parity = 3'd3;
    localparam logic [2:0] c_st_stop1  = 3'd4;
    localparam logic [2:0] c_st_stop2  = 3'd5;

    logic [2:0]           r_state;
    logic [2:0]           w_state_nxt;
    logic                 r_sync1, r_sync2, r_rxd_prev;
    logic                 w_fall;
    logic [15:0]          r_baud_cnt, r_div;
    logic                 w_tick;
    logic [c_TICK_W-1:0]  r_tick_cnt;
    logic                 w_sample, w_bit_end, w_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic [3:0]           r_bit_cnt;
    logic                 r_par_acc, r_perr, r_ferr, r_done;
    logic [1:0]           r_par_mode;
    logic                 r_stop2;
    logic                 w_par_on;
    logic                 w_start_frame, w_shift_en, w_par_en, w_stop_en, w_frame_end;

    // Synchroniser plus one extra stage for falling-edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_rxd_prev <= 1'b1;
        end else begin
            r_sync1    <= rxd;
            r_sync2    <= r_sync1;
            r_rxd_prev <= r_sync2;
        end
    end
    assign w_fall = r_rxd_prev & ~r_sync2;

    // Divider reload happens only on wrap so a live baud_div change never truncates a tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_baud_cnt <= '0;
            r_div      <= '0;
        end else if (!rx_en) begin
            r_baud_cnt <= '0;
            r_div      <= baud_div;
        end else if (r_baud_cnt >= r_div) begin
            r_baud_cnt <= '0;
            r_div      <= baud_div;
        end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
        end
    end
    assign w_tick = rx_en && (r_baud_cnt >= r_div);

    assign w_sample  = w_tick && (r_state != c_st_idle) && (r_tick_cnt == c_vote_tick);
    assign w_bit_end = w_tick && (r_tick_cnt == c_last_tick);
    assign w_par_on  = (r_par_mode == 2'b01) || (r_par_mode == 2'b10);

`ifdef UART_RX_MAJORITY_EN
    logic r_m0, r_m1;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_m0 <= 1'b1;
            r_m1 <= 1'b1;
        end else if (w_tick) begin
            if (r_tick_cnt == c_m0_tick) r_m0 <= r_sync2;
            if (r_tick_cnt == c_m1_tick) r_m1 <= r_sync2;
        end
    end
    assign w_bit = (r_m0 & r_m1) | (r_m0 & r_sync2) | (r_m1 & r_sync2);
`else
    assign w_bit = r_sync2;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= c_st_idle;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!rx_en) begin
            w_state_nxt = c_st_idle;
        end else begin
            case (r_state)
                c_st_idle:   if (w_fall) w_state_nxt = c_st_start;
                c_st_start: begin
                    if (w_sample && w_bit) w_state_nxt = c_st_idle;
                    else if (w_bit_end)    w_state_nxt = c_st_data;
                end
                c_st_data:
                    if (w_bit_end && (r_bit_cnt == 4'(DATA_BITS)))
                        w_state_nxt = w_par_on ? c_st_parity : c_st_stop1;
                c_st_parity: if (w_bit_end) w_state_nxt = c_st_stop1;
                c_st_stop1: begin
                    if (w_sample && !r_stop2) w_state_nxt = c_st_idle;
                    else if (w_bit_end)       w_state_nxt = c_st_stop2;
                end
                c_st_stop2:  if (w_sample) w_state_nxt = c_st_idle;
                default:     w_state_nxt = c_st_idle;
            endcase
        end
    end

    always_comb begin
        w_start_frame = (r_state == c_st_idle) && rx_en && w_fall;
        w_shift_en    = (r_state == c_st_data) && w_sample;
        w_par_en      = (r_state == c_st_parity) && w_sample;
        w_stop_en     = ((r_state == c_st_stop1) || (r_state == c_st_stop2)) && w_sample;
        w_frame_end   = w_stop_en && ((r_state == c_st_stop2) || !r_stop2);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (!rx_en || (r_state == c_st_idle) || (w_state_nxt == c_st_idle)) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= (r_tick_cnt == c_last_tick) ? '0 : r_tick_cnt + 1'b1;
        end
    end

    // Framing options are frozen at the start edge for the whole frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_par_acc  <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_par_mode <= 2'b00;
            r_stop2    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_frame_end;
            if (w_start_frame) begin
                r_par_mode <= parity_mode;
                r_stop2    <= stop2;
                r_bit_cnt  <= '0;
                r_par_acc  <= 1'b0;
                r_perr     <= 1'b0;
                r_ferr     <= 1'b0;
            end
            if (w_shift_en) begin
                r_shift   <= {w_bit, r_shift[DATA_BITS-1:1]};
                r_bit_cnt <= r_bit_cnt + 4'd1;
                r_par_acc <= r_par_acc ^ w_bit;
            end
            if (w_par_en)
                r_perr <= w_bit ^ r_par_acc ^ (r_par_mode == 2'b10);
            if (w_stop_en && !w_bit)
                r_ferr <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_ferror  <= 1'b0;
            rx_perror  <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            if (r_done && (!rx_valid || rx_ready)) begin
                rx_data   <= r_shift;
                rx_ferror <= r_ferr;
                rx_perror <= r_perr;
                rx_valid  <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid  <= 1'b0;
            end
            if (rx_valid && rx_ready)
                rx_overrun <= 1'b0;
            else if (r_done && rx_valid)
                rx_overrun <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_configurable.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_configurable
// Brief    : Directed and randomized frames checked against a frame-level
//            model of the receiver and its holding register.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_configurable;

    localparam int DB = 8;
    localparam int OS = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rx_en = 1'b0;
    logic [15:0]   baud_div = '0;
    logic [1:0]    parity_mode = 2'b00;
    logic          stop2 = 1'b0;
    logic          rxd = 1'b1;
    logic          rx_ready = 1'b0;
    logic [DB-1:0] rx_data;
    logic          rx_valid, rx_ferror, rx_perror, rx_overrun;

    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    exp_t       exp_q[$];
    logic       model_ovr = 1'b0;
    int         checks = 0;
    int         errors = 0;
    int         valid_cycles = 0;
    logic [7:0] last_data = '0;
    logic       last_fe = 1'b0;
    logic       last_pe = 1'b0;

    always #5 clk = ~clk;

    uart_rx_configurable #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
        .clk(clk), .reset(reset), .rx_en(rx_en), .baud_div(baud_div),
        .parity_mode(parity_mode), .stop2(stop2), .rxd(rxd), .rx_ready(rx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ferror(rx_ferror),
        .rx_perror(rx_perror), .rx_overrun(rx_overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Frame-level expectation straight from the line contents
    function automatic exp_t model_frame(input logic [7:0] d, input logic [1:0] pm,
                                         input logic pbit, input logic s1, input logic s2,
                                         input logic two);
        exp_t e;
        int   ones;
        ones = 0;
        for (int i = 0; i < DB; i++) ones += int'(d[i]);
        e.d  = d;
        if (pm == 2'b01)      e.pe = (pbit != ((ones % 2) == 1));
        else if (pm == 2'b10) e.pe = (pbit != ((ones % 2) == 0));
        else                  e.pe = 1'b0;
        e.fe = !s1 || (two && !s2);
        return e;
    endfunction

    task automatic hold(input logic b, input int n);
        rxd = b;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] d, input logic [1:0] pm, input logic pbit,
                        input logic s1, input logic s2, input logic two, input int glitch_bit);
        int bt;
        bt = OS * (int'(baud_div) + 1);
        hold(1'b0, bt);
        for (int i = 0; i < DB; i++) begin
            if (i == glitch_bit) begin
                hold(d[i], bt / 2);
                hold(~d[i], 1);
                hold(d[i], bt - bt / 2 - 1);
            end else begin
                hold(d[i], bt);
            end
        end
        if (pm == 2'b01 || pm == 2'b10) hold(pbit, bt);
        hold(s1, bt);
        if (two) hold(s2, bt);
    endtask

    task automatic quiet();
        check("idle_valid", rx_valid, (exp_q.size() != 0));
        check("idle_overrun", rx_overrun, model_ovr);
        if (rx_ready) exp_q.delete();
    endtask

    task automatic frame(input logic [7:0] d, input logic [1:0] pm, input logic pbit,
                         input logic s1, input logic s2, input logic two,
                         input logic rdy, input int glitch_bit);
        exp_t e;
        int   bt;
        e = model_frame(d, pm, pbit, s1, s2, two);
        parity_mode = pm;
        stop2       = two;
        if (rdy && !rx_ready) begin
            rx_ready  = 1'b1;
            hold(1'b1, 4);
            model_ovr = 1'b0;
        end
        rx_ready = rdy;
        if (exp_q.size() == 0) exp_q.push_back(e);
        else                   model_ovr = 1'b1;
        send(d, pm, pbit, s1, s2, two, glitch_bit);
        bt = OS * (int'(baud_div) + 1);
        hold(1'b1, 2 * bt);
        quiet();
    endtask

    // Output checker: every cycle with a held word is compared to the model
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && rx_valid) begin
                valid_cycles++;
                if (exp_q.size() == 0) begin
                    check("spurious_valid", rx_valid, 1'b0);
                end else begin
                    check("rx_data", rx_data, exp_q[0].d);
                    check("rx_ferror", rx_ferror, exp_q[0].fe);
                    check("rx_perror", rx_perror, exp_q[0].pe);
                    if (rx_ready) begin
                        last_data = rx_data;
                        last_fe   = rx_ferror;
                        last_pe   = rx_perror;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #950000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] v;
        int         vc0;
        int         bt;

        repeat (3) @(posedge clk);
        #1;
        check("reset_data", rx_data, 0);
        check("reset_valid", rx_valid, 0);
        check("reset_ferror", rx_ferror, 0);
        check("reset_perror", rx_perror, 0);
        check("reset_overrun", rx_overrun, 0);
        reset = 1'b0;
        rx_en = 1'b1;
        hold(1'b1, 20);

        valid_cycles = 0;
        frame(8'hA5, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, -1);
        check("a5_data", last_data, 8'hA5);
        check("a5_perror", last_pe, 1'b0);
        check("a5_ferror", last_fe, 1'b0);
        check("a5_valid_cycles", valid_cycles, 1);

        frame(8'h3C, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, -1);
        check("3c_data", last_data, 8'h3C);
        check("3c_perror", last_pe, 1'b1);

        frame(8'h81, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, -1);
        check("81_data", last_data, 8'h81);
        check("81_ferror", last_fe, 1'b1);

        frame(8'h11, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, -1);
        frame(8'h22, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, -1);
        check("ovr_data", rx_data, 8'h11);
        check("ovr_valid", rx_valid, 1'b1);
        check("ovr_flag", rx_overrun, 1'b1);
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready  = 1'b0;
        model_ovr = 1'b0;
        check("hs_valid", rx_valid, 1'b0);
        check("hs_overrun", rx_overrun, 1'b0);

        vc0 = valid_cycles;
        hold(1'b0, 3);
        hold(1'b1, 3 * OS);
        check("glitch_no_valid", valid_cycles, vc0);
        quiet();
        frame(8'hC3, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, -1);
        check("after_glitch_data", last_data, 8'hC3);
`ifdef UART_RX_MAJORITY_EN
        frame(8'hFF, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3);
        check("majority_data", last_data, 8'hFF);
`endif

        frame(8'h33, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        frame(8'h44, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, -1);
        v  = 8'h5A;
        bt = OS;
        parity_mode = 2'b00;
        stop2       = 1'b0;
        hold(1'b0, bt);
        for (int i = 0; i < 4; i++) hold(v[i], bt);
        hold(v[4], bt / 2);
        reset = 1'b1;
        #2;
        exp_q.delete();
        model_ovr = 1'b0;
        check("midreset_data", rx_data, 0);
        check("midreset_valid", rx_valid, 0);
        check("midreset_ferror", rx_ferror, 0);
        check("midreset_perror", rx_perror, 0);
        check("midreset_overrun", rx_overrun, 0);
        rxd = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        hold(1'b1, 2 * bt);
        frame(v, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, -1);
        check("after_reset_data", last_data, 8'h5A);

        for (int n = 0; n < 40; n++) begin
            logic [7:0] d;
            logic [1:0] pm;
            logic       pbit, s1, s2, two, rdy;
            baud_div = 16'($urandom_range(0, 2));
            hold(1'b1, 8);
            bt = OS * (int'(baud_div) + 1);
            if ($urandom_range(0, 7) == 0) begin
                hold(1'b0, bt);
                hold(1'($urandom_range(0, 1)), bt * int'($urandom_range(1, 5)));
                rx_en = 1'b0;
                hold(1'b1, 5);
                rx_en = 1'b1;
                hold(1'b1, bt);
                quiet();
            end
            d    = 8'($urandom_range(0, 255));
            pm   = 2'($urandom_range(0, 3));
            two  = 1'($urandom_range(0, 1));
            pbit = (pm == 2'b10) ? ~(^d) : (^d);
            if ($urandom_range(0, 3) == 0) pbit = ~pbit;
            s1   = ($urandom_range(0, 7) != 0);
            s2   = ($urandom_range(0, 7) != 0);
            rdy  = ($urandom_range(0, 3) != 0);
            frame(d, pm, pbit, s1, s2, two, rdy, -1);
        end

        rx_ready = 1'b1;
        hold(1'b1, 4);
        model_ovr = 1'b0;
        quiet();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_configurable.md
UART_RX_CONFIGURABLE -- requirements
Module: uart_rx_configurable

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (legal range 5..9).
REQ-002 SHALL have parameter OVERSAMPLE, default 16, meaning sample ticks per bit (legal values 8 or 16).
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port rx_en  input  1  receiver enable.
REQ-006 SHALL have port baud_div  input  16  sample-tick period minus one, in clk cycles.
REQ-007 SHALL have port parity_mode  input  2  00 none, 01 even, 10 odd, 11 treated as none.
REQ-008 SHALL have port stop2  input  1  1 selects two stop bits, 0 selects one.
REQ-009 SHALL have port rxd  input  1  asynchronous serial line, idle high.
REQ-010 SHALL have port rx_ready  input  1  consumer accepts rx_data.
REQ-011 SHALL have port rx_data  output  DATA_BITS  received word, LSB first on line.
REQ-012 SHALL have port rx_valid  output  1  rx_data and flags valid.
REQ-013 SHALL have port rx_ferror  output  1  framing error for the held word.
REQ-014 SHALL have port rx_perror  output  1  parity error for the held word.
REQ-015 SHALL have port rx_overrun  output  1  sticky: a frame was lost.

Function
REQ-016 SHALL pass rxd through a 2-flop synchroniser; all decisions use the synchronised value.
REQ-017 SHALL generate one sample tick every baud_div+1 clk cycles while rx_en=1; a baud_div change takes effect at the next tick-counter wrap.
REQ-018 SHALL implement states IDLE, START, DATA, PARITY, STOP1, STOP2, with a per-bit tick counter 0..OVERSAMPLE-1.
REQ-019 SHALL move IDLE->START on a synchronised 1->0 transition and clear the tick counter.
REQ-020 SHALL sample each bit at tick OVERSAMPLE/2-1; a START sample of 1 SHALL return to IDLE with no flags set (glitch rejection).
REQ-021 SHALL shift DATA_BITS samples LSB first, then go to PARITY if parity_mode is 01 or 10, else to STOP1.
REQ-022 SHALL set the frame perror when the received parity bit differs from the XOR of the data bits (even) or its inverse (odd).
REQ-023 SHALL set the frame ferror if any stop-bit sample is 0; STOP1 goes to STOP2 when stop2=1.
REQ-024 SHALL, on the clk edge after the last stop sample, load rx_data/rx_ferror/rx_perror, assert rx_valid, and go to IDLE (an errored frame is still delivered).
REQ-025 SHALL hold rx_valid and the held word until a cycle with rx_valid=1 and rx_ready=1, after which rx_valid deasserts.
REQ-026 SHALL, if a frame completes while rx_valid=1 and rx_ready=0, discard the new frame, keep the old word, and set rx_overrun.
REQ-027 SHALL, if a frame completes in the same cycle as a handshake, load the new word and keep rx_valid=1 with no overrun.
REQ-028 SHALL clear rx_overrun only on a handshake cycle.
REQ-029 SHALL, when rx_en=0, force IDLE, stop the tick generator, and discard a partial frame without flags; the holding register and rx_valid are unaffected.
REQ-030 SHALL sample parity_mode, stop2 and DATA_BITS framing once at the IDLE->START transition, for the whole frame.

Reset
REQ-031 SHALL, on reset, immediately set state IDLE, counters 0, synchroniser flops 1, rx_data 0, and rx_valid, rx_ferror, rx_perror, rx_overrun 0.
REQ-032 SHALL, on reset asserted mid-frame, discard the frame; reception resumes on the first falling edge after reset deasserts.

Configuration
REQ-033 SHALL, with macro UART_RX_MAJORITY_EN defined, decide each bit by a 2-of-3 majority of samples at ticks OVERSAMPLE/2-2, OVERSAMPLE/2-1 and OVERSAMPLE/2, with the vote resolved at tick OVERSAMPLE/2.
REQ-034 SHALL, without UART_RX_MAJORITY_EN, use the single sample at tick OVERSAMPLE/2-1; all other behaviour is identical.

Verification
REQ-035 SHALL cover: baud_div=0, parity_mode=01, rx_ready=1, frame 0xA5 with parity 0 -> rx_data=0xA5, rx_valid for 1 cycle, ferror=0, perror=0.
REQ-036 SHALL cover: parity_mode=10, frame 0x3C with parity bit 0 -> rx_perror=1, rx_data=0x3C.
REQ-037 SHALL cover: stop2=1, second stop bit driven 0, byte 0x81 -> rx_ferror=1, rx_data=0x81.
REQ-038 SHALL cover: rx_ready=0, frames 0x11 then 0x22 -> rx_data stays 0x11 and rx_overrun=1; the handshake clears both rx_valid and rx_overrun.
REQ-039 SHALL cover: a low pulse of 3 ticks on idle rxd -> no rx_valid, state returns to IDLE; with UART_RX_MAJORITY_EN, a 1-tick glitch at a mid-bit sample of data 0xFF -> rx_data=0xFF.
REQ-040 SHALL cover: reset pulsed during data bit 4 -> all outputs 0; a following 0x5A frame is received correctly.
